// File: rtl/pixel_frame_assembler_if.sv
// Byte-stream input and pixel/frame output bundle of the pixel frame assembler.
// The slave modport is the assembler's view; master is the FIFO/RAM side.
interface pixel_frame_assembler_if #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 10
);
    localparam int ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT);

    logic              empty;
    logic [7:0]        pop_data;
    logic              pop;
    logic [1:0]        pix_fmt;
    logic [23:0]       rgb_data;
    logic              pixel_done;
    logic [ADDR_W-1:0] pixel_cnt;
    logic              frame_done;
    logic [7:0]        frame_cnt;
    logic              busy;
    logic              timeout_err;

    modport master (
        output empty, pop_data, pix_fmt,
        input  pop, rgb_data, pixel_done, pixel_cnt, frame_done, frame_cnt, busy, timeout_err
    );

    modport slave (
        input  empty, pop_data, pix_fmt,
        output pop, rgb_data, pixel_done, pixel_cnt, frame_done, frame_cnt, busy, timeout_err
    );
endinterface

// File: rtl/pixel_frame_assembler.sv
// Waits for a sync byte, then assembles RGB888/RGB565/GRAY8 pixels from a FWFT byte FIFO
// into RAM write strobes, with frame completion pulse, frame counter and idle-timeout abort.
module pixel_frame_assembler #(
    parameter int         DATA_WIDTH  = 8,
    parameter int         IMG_WIDTH   = 8,
    parameter int         IMG_HEIGHT  = 10,
    parameter logic [7:0] SYNC_BYTE   = 8'hAA,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_frame_assembler_if.slave bus
);
    localparam int NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_W  = $clog2(NUM_PIX);
    localparam int IDLE_W  = $clog2(TIMEOUT_CYC);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            fmt_reg, fmt_next;
    logic [1:0]            byte_idx_reg, byte_idx_next;
    logic [DATA_WIDTH-1:0] b0_reg, b0_next;
    logic [DATA_WIDTH-1:0] b1_reg, b1_next;
    logic [23:0]           rgb_reg, rgb_next;
    logic                  pixel_done_reg, pixel_done_next;
    logic [ADDR_W-1:0]     pixel_cnt_reg, pixel_cnt_next;
    logic [7:0]            frame_cnt_reg, frame_cnt_next;
    logic                  timeout_reg, timeout_next;
    logic [IDLE_W-1:0]     idle_reg, idle_next;

    logic        pop_int;
    logic        last_hold;
    logic [1:0]  last_idx;
    logic [15:0] w565;

    // The cycle showing the final pixel's write must not consume a byte of the next frame.
    assign last_hold = pixel_done_reg && (pixel_cnt_reg == LAST_ADDR);
    assign pop_int   = reset && !bus.empty &&
                       ((state_reg == IDLE) || ((state_reg == COLLECT) && !last_hold));
    assign w565      = {b0_reg, bus.pop_data};

    always_comb begin
        state_next      = state_reg;
        fmt_next        = fmt_reg;
        byte_idx_next   = byte_idx_reg;
        b0_next         = b0_reg;
        b1_next         = b1_reg;
        rgb_next        = rgb_reg;
        pixel_done_next = 1'b0;
        pixel_cnt_next  = pixel_cnt_reg;
        frame_cnt_next  = frame_cnt_reg;
        timeout_next    = timeout_reg;
        idle_next       = idle_reg;

        case (fmt_reg)
            2'd1:    last_idx = 2'd1;
            2'd2:    last_idx = 2'd0;
            default: last_idx = 2'd2;
        endcase

        case (state_reg)
            IDLE: begin
                if (pop_int && (bus.pop_data == SYNC_BYTE)) begin
                    fmt_next       = bus.pix_fmt;
                    byte_idx_next  = 2'd0;
                    pixel_cnt_next = '0;
                    idle_next      = '0;
                    timeout_next   = 1'b0;
                    state_next     = COLLECT;
                end
            end
            COLLECT: begin
                if (pixel_done_reg)
                    pixel_cnt_next = (pixel_cnt_reg == LAST_ADDR) ? '0 : pixel_cnt_reg + 1'b1;
                if (last_hold) begin
                    state_next     = DONE;
                    frame_cnt_next = frame_cnt_reg + 8'd1;
                end else if (pop_int) begin
                    idle_next = '0;
                    if (byte_idx_reg == 2'd0) b0_next = bus.pop_data;
                    if (byte_idx_reg == 2'd1) b1_next = bus.pop_data;
                    if (byte_idx_reg == last_idx) begin
                        byte_idx_next   = 2'd0;
                        pixel_done_next = 1'b1;
                        case (fmt_reg)
                            2'd1:    rgb_next = {w565[15:11], w565[15:13], w565[10:5], w565[10:9],
                                                 w565[4:0], w565[4:2]};
                            2'd2:    rgb_next = {bus.pop_data, bus.pop_data, bus.pop_data};
                            default: rgb_next = {b0_reg, b1_reg, bus.pop_data};
                        endcase
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                    end
                end else if (idle_reg == IDLE_MAX) begin
                    // Stalled source: abandon the partial frame and resynchronise.
                    timeout_next   = 1'b1;
                    pixel_cnt_next = '0;
                    byte_idx_next  = 2'd0;
                    idle_next      = '0;
                    state_next     = IDLE;
                end else begin
                    idle_next = idle_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            fmt_reg        <= 2'd0;
            byte_idx_reg   <= 2'd0;
            b0_reg         <= '0;
            b1_reg         <= '0;
            rgb_reg        <= '0;
            pixel_done_reg <= 1'b0;
            pixel_cnt_reg  <= '0;
            frame_cnt_reg  <= '0;
            timeout_reg    <= 1'b0;
            idle_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            fmt_reg        <= fmt_next;
            byte_idx_reg   <= byte_idx_next;
            b0_reg         <= b0_next;
            b1_reg         <= b1_next;
            rgb_reg        <= rgb_next;
            pixel_done_reg <= pixel_done_next;
            pixel_cnt_reg  <= pixel_cnt_next;
            frame_cnt_reg  <= frame_cnt_next;
            timeout_reg    <= timeout_next;
            idle_reg       <= idle_next;
        end
    end

    assign bus.pop         = pop_int;
    assign bus.rgb_data    = rgb_reg;
    assign bus.pixel_done  = pixel_done_reg;
    assign bus.pixel_cnt   = pixel_cnt_reg;
    assign bus.frame_done  = (state_reg == DONE);
    assign bus.frame_cnt   = frame_cnt_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.timeout_err = timeout_reg;
endmodule

// File: tb/tb_pixel_frame_assembler.sv
// Scoreboard bench: a FWFT FIFO model feeds bytes, expected pixels/frames are queued by the
// stimulus and a negedge monitor pops and compares each pixel_done / frame_done.
module tb_pixel_frame_assembler;
    localparam int TO = 20;

    typedef struct {
        logic [6:0]  addr;
        logic [23:0] rgb;
    } pix_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] fifo_q[$];
    pix_t       pix_exp_q[$];
    logic [7:0] frame_exp_q[$];

    logic       prev_pd   = 1'b0;
    logic [6:0] prev_addr = 7'd0;
    int         run_len   = 0;

    always #5 clk = ~clk;

    pixel_frame_assembler_if #(.IMG_WIDTH(8), .IMG_HEIGHT(10)) bus ();

    pixel_frame_assembler #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (8),
        .IMG_HEIGHT (10),
        .SYNC_BYTE  (8'hAA),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic expect_pix(input int addr, input logic [23:0] rgb);
        pix_t p;
        p.addr = 7'(addr);
        p.rgb  = rgb;
        pix_exp_q.push_back(p);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((pix_exp_q.size() != 0 || frame_exp_q.size() != 0) && n < 2000) begin
            @(negedge clk); #3;
            n++;
        end
        chk(name, 32'(pix_exp_q.size() + frame_exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        #3;
    endtask

    // FIFO model: present head byte at negedge, consume it at the posedge where pop was high.
    initial begin
        logic       will_pop;
        logic [7:0] junk;
        bus.empty    = 1'b1;
        bus.pop_data = 8'h00;
        forever begin
            @(negedge clk);
            bus.empty    = (fifo_q.size() == 0);
            bus.pop_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
            #1;
            will_pop = bus.pop;
            @(posedge clk);
            if (will_pop && fifo_q.size() != 0) junk = fifo_q.pop_front();
        end
    end

    // Monitor / scoreboard.
    initial begin
        pix_t       p;
        logic [7:0] fc;
        forever begin
            @(negedge clk); #2;
            if (bus.pixel_done) begin
                $display("pixel addr=%0d rgb=%06h", bus.pixel_cnt, bus.rgb_data);
                if (pix_exp_q.size() == 0) begin
                    chk("pixel_unexpected", 32'(bus.pixel_done), 32'd0);
                end else begin
                    p = pix_exp_q.pop_front();
                    chk("pixel_addr", 32'(bus.pixel_cnt), 32'(p.addr));
                    chk("pixel_rgb", 32'(bus.rgb_data), 32'(p.rgb));
                end
                run_len = prev_pd ? run_len + 1 : 1;
            end
            if (bus.frame_done) begin
                $display("frame done frame_cnt=%0d", bus.frame_cnt);
                if (frame_exp_q.size() == 0) begin
                    chk("frame_unexpected", 32'(bus.frame_done), 32'd0);
                end else begin
                    fc = frame_exp_q.pop_front();
                    chk("frame_cnt", 32'(bus.frame_cnt), 32'(fc));
                    chk("frame_after_last_pixel", 32'({prev_pd, prev_addr}), 32'({1'b1, 7'd79}));
                end
            end
            prev_pd = bus.pixel_done;
            if (bus.pixel_done) prev_addr = bus.pixel_cnt;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.pix_fmt = 2'd0;

        // Reset state, with a byte waiting so pop would otherwise be asserted.
        push_byte(8'h11);
        repeat (3) @(negedge clk);
        #3;
        chk("rst_rgb_data", 32'(bus.rgb_data), 32'd0);
        chk("rst_pixel_done", 32'(bus.pixel_done), 32'd0);
        chk("rst_pixel_cnt", 32'(bus.pixel_cnt), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_pop", 32'(bus.pop), 32'd0);
        reset = 1'b1;

        // RGB888 frame after garbage; a 0xAA inside the frame is plain data.
        push_byte(8'h22);
        push_byte(8'hAA);
        for (int i = 0; i < 240; i++) push_byte((i == 0) ? 8'hAA : 8'(i));
        for (int k = 0; k < 80; k++)
            expect_pix(k, (k == 0) ? 24'hAA0102 : {8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)});
        frame_exp_q.push_back(8'd1);
        wait_drain("drain_rgb888");
        chk("pixel_cnt_wrap", 32'(bus.pixel_cnt), 32'd0);
        chk("idle_after_frame", 32'(bus.busy), 32'd0);

        // RGB565 frame; pix_fmt changes mid-frame must be ignored.
        bus.pix_fmt = 2'd1;
        push_byte(8'hAA);
        push_byte(8'hF8); push_byte(8'h00);
        push_byte(8'h07); push_byte(8'hE0);
        push_byte(8'h00); push_byte(8'h1F);
        push_byte(8'h84); push_byte(8'h10);
        for (int i = 0; i < 152; i++) push_byte(8'hFF);
        expect_pix(0, 24'hFF0000);
        expect_pix(1, 24'h00FF00);
        expect_pix(2, 24'h0000FF);
        expect_pix(3, 24'h848284);
        for (int k = 4; k < 80; k++) expect_pix(k, 24'hFFFFFF);
        frame_exp_q.push_back(8'd2);
        repeat (20) @(negedge clk);
        bus.pix_fmt = 2'd2;
        wait_drain("drain_rgb565");

        // GRAY8 frame: pixel_done on 80 consecutive cycles.
        push_byte(8'hAA);
        for (int i = 0; i < 80; i++) push_byte(8'h5A);
        for (int k = 0; k < 80; k++) expect_pix(k, 24'h5A5A5A);
        frame_exp_q.push_back(8'd3);
        wait_drain("drain_gray8");
        chk("gray8_back_to_back", 32'(run_len), 32'd80);

        // Timeout: one full pixel plus a partial one, then the source stalls.
        bus.pix_fmt = 2'd0;
        push_byte(8'hAA);
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
        expect_pix(0, 24'h010203);
        n = 0;
        while (fifo_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (TO - 2) @(negedge clk);
        #3;
        chk("timeout_not_yet", 32'(bus.timeout_err), 32'd0);
        chk("busy_before_timeout", 32'(bus.busy), 32'd1);
        repeat (3) @(negedge clk);
        #3;
        chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);
        chk("busy_after_timeout", 32'(bus.busy), 32'd0);
        chk("pixel_cnt_after_timeout", 32'(bus.pixel_cnt), 32'd0);
        chk("frame_cnt_after_timeout", 32'(bus.frame_cnt), 32'd3);

        // New sync clears the error and restarts at address 0; reset lands at pixel 40.
        push_byte(8'hAA);
        for (int i = 0; i < 240; i++) push_byte(8'(i + 7));
        for (int k = 0; k <= 40; k++) expect_pix(k, {8'(3 * k + 7), 8'(3 * k + 8), 8'(3 * k + 9)});
        n = 0;
        while (pix_exp_q.size() != 0 && n < 1000) begin
            @(negedge clk); #3;
            n++;
        end
        chk("reach_pixel_40", 32'(pix_exp_q.size()), 32'd0);
        chk("timeout_err_cleared", 32'(bus.timeout_err), 32'd0);
        chk("busy_mid_frame", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        fifo_q.delete();
        @(negedge clk);
        #3;
        chk("mid_rst_rgb_data", 32'(bus.rgb_data), 32'd0);
        chk("mid_rst_pixel_done", 32'(bus.pixel_done), 32'd0);
        chk("mid_rst_pixel_cnt", 32'(bus.pixel_cnt), 32'd0);
        chk("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("mid_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        reset = 1'b1;

        // A full frame after the mid-frame reset completes normally.
        bus.pix_fmt = 2'd2;
        push_byte(8'hAA);
        for (int i = 0; i < 80; i++) push_byte(8'(i));
        for (int k = 0; k < 80; k++) expect_pix(k, {8'(k), 8'(k), 8'(k)});
        frame_exp_q.push_back(8'd1);
        wait_drain("drain_after_reset");
        chk("frame_cnt_final", 32'(bus.frame_cnt), 32'd1);
        chk("busy_final", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
